mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Memory-side stage directly downstream of the 16-bit accumulator CPU.
- Accepts one word request at a time: read or write, direct or indirect addressing, 10-bit word address.
- Resolves indirect addresses by a pointer fetch, performs the access on an internal synchronous single-port RAM, and returns read data (or echoed write data) with a one-cycle response strobe.

Parameters:
- AW, 10, address width in words.
- DW, 16, data word width.
- DEPTH, 1024, RAM words implemented (DEPTH <= 2**AW).
- ROM_TOP, 64, first writable address; used only when ROM_PROTECT_EN is defined.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_wr  input  1  1 = write, 0 = read.
- req_indirect  input  1  1 = req_addr points to a word whose low AW bits are the effective address.
- req_addr  input  AW  request address.
- req_wdata  input  DW  write data.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  DW  read data; on writes, the data written.
- rsp_ea  output  AW  effective address actually accessed.
- busy  output  1  FSM not in IDLE.
- rsp_err  output  1  present only with ROM_PROTECT_EN.

Behaviour:
- Reset (async assert, sync deassert by the system): FSM=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_ea=0; busy=0; rsp_err=0. RAM contents are not reset.
- FSM states: IDLE, PTR, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch wr, wdata and addr.
  - If indirect: issue a RAM read of req_addr and go to PTR.
  - Else: ea <= req_addr and go to ACCESS.
- PTR: ea <= ram_q[AW-1:0]; pointer bits above AW are ignored; go to ACCESS.
- ACCESS:
  - Write: mem[ea] <= wdata.
  - Read: issue a RAM read of ea.
  - Go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - rsp_rdata = ram_q for reads, latched wdata for writes.
  - rsp_ea = ea.
  - Go to IDLE.
- req_ready=0 and busy=1 in every state except IDLE. Requests are never queued. req_valid outside IDLE is ignored.
- Latency from the accept edge to rsp_valid: direct = 2 cycles, indirect = 3 cycles. Minimum issue interval: 3 cycles direct, 4 cycles indirect.
- No response backpressure; the consumer must sample on rsp_valid.
- rsp_rdata and rsp_ea hold their values until the next RESP.
- Out-of-range (ea >= DEPTH):
  - Writes are dropped.
  - Reads return 0.
  - rsp_ea still reports ea.
- Read-after-write to the same address in consecutive requests returns the new data. No bypass is needed, because the write completes in ACCESS before the next accept.
- Reset mid-operation: FSM returns to IDLE immediately. A write not yet reached ACCESS is lost. No rsp_valid is produced for the aborted request.
- A self-pointing indirect (mem[a] low bits == a) is legal; it accesses a.

Optional Feature:
- Macro: ROM_PROTECT_EN.
- With the macro defined:
  - Writes with ea < ROM_TOP are suppressed.
  - rsp_err=1 alongside rsp_valid for that response; rsp_rdata echoes wdata.
  - Out-of-range accesses also set rsp_err.
  - rsp_err is otherwise 0.
- Without the macro: all in-range addresses are writable and the rsp_err port does not exist.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, PTR, ACCESS, RESP).
  - Word-width and address-width constants shared with the CPU (16, 10).
- Sub-module: sp_ram (single-port, synchronous read, one-cycle latency, write-first not required) holds the storage.
- The FSM and request/response registers stay in mem_bus_ctrl.

Test Plan:
- After reset, direct write addr=0x100 data=0xBEEF, then direct read 0x100 -> rsp_valid 2 cycles after each accept; read gives rsp_rdata=0xBEEF, rsp_ea=0x100.
- Preload mem[0x020]=0xFC55, mem[0x055]=0x1234; indirect read addr=0x020 -> 3-cycle latency; rsp_ea=0x055 (upper pointer bits ignored), rsp_rdata=0x1234.
- Hold req_valid high continuously with 3 direct reads -> req_ready low in PTR/ACCESS/RESP; exactly 3 accepts; responses spaced 3 cycles apart, in order.
- Accept a direct write of 0xAAAA to 0x010; assert rst_n=0 during PTR/ACCESS before the write lands (use an indirect write so the abort precedes ACCESS) -> outputs go to reset values asynchronously; no rsp_valid; after reset, reading 0x010 returns its prior value.
- DEPTH=512: write 0x0300 with data 0x5555, then read 0x0300 -> rsp_rdata=0, rsp_ea=0x300; with ROM_PROTECT_EN, rsp_err=1.
- ROM_PROTECT_EN, ROM_TOP=64: write 0x0010 with data 0x7777 -> rsp_err=1, mem[0x10] unchanged; write 0x0040 -> rsp_err=0, stored.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and widths for the memory-side stage of the 16-bit accumulator CPU.
// Holds the controller FSM state encoding and the CPU word/address widths.
// Optional feature macro used by importers: ROM_PROTECT_EN.
package mem_bus_ctrl_pkg;

  // Word and address widths shared with the CPU.
  localparam int CPU_DW = 16;
  localparam int CPU_AW = 10;

  // Controller FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PTR    = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/mem_bus_ctrl_sp_ram.sv
// Single-port synchronous RAM: one read or write per cycle, shared address.
// Latency: read data appears one cycle after the address is presented.
// Backpressure: none; accepts an access every cycle. Contents are not reset.
module mem_bus_ctrl_sp_ram #(
  parameter int DW    = 16,
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_q;

  // Storage write plus registered read; read data during a write is don't-care.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: one word request at a time, direct or indirect (pointer fetch).
// Latency: accept edge to rsp_valid is 2 cycles direct, 3 cycles indirect.
// Backpressure: req_ready low while busy; no response backpressure. Option: ROM_PROTECT_EN.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int AW      = CPU_AW,
  parameter int DW      = CPU_DW,
  parameter int DEPTH   = 1024,
  parameter int ROM_TOP = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic          req_indirect,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] rsp_ea,
  output logic          busy
`ifdef ROM_PROTECT_EN
  ,
  output logic          rsp_err
`endif
);

  // RAM address width covers only the implemented words.
  localparam int RAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
`ifdef ROM_PROTECT_EN
  localparam logic [AW:0] LP_ROM_TOP = (AW+1)'(ROM_TOP);
`endif

  state_e        r_state;
  logic          r_wr;
  logic [DW-1:0] r_wdata;
  logic [AW-1:0] r_ea;
  logic          r_req_ready;
  logic          r_busy;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rdata;
  logic [AW-1:0] r_rsp_ea;
`ifdef ROM_PROTECT_EN
  logic          r_err;
  logic          w_rom_hit;
`endif

  logic [RAW-1:0] w_ram_addr;
  logic           w_ram_we;
  logic [DW-1:0]  w_ram_q;
  logic           w_ea_oob;
  logic           w_wr_block;
  logic [DW-1:0]  w_rd_data;

  // Address decode of the effective address: out-of-range and write-protect checks.
  always_comb begin
    w_ea_oob = ({1'b0, r_ea} >= LP_DEPTH);
`ifdef ROM_PROTECT_EN
    w_rom_hit  = ({1'b0, r_ea} < LP_ROM_TOP);
    w_wr_block = w_ea_oob | w_rom_hit;
`else
    w_wr_block = w_ea_oob;
`endif
  end

  // RAM port steering: IDLE presents the request address so a pointer read starts at accept.
  always_comb begin
    w_ram_addr = r_ea[RAW-1:0];
    if (r_state == ST_IDLE) begin
      w_ram_addr = req_addr[RAW-1:0];
    end
    w_ram_we = (r_state == ST_ACCESS) && r_wr && !w_wr_block;
  end

  mem_bus_ctrl_sp_ram #(
    .DW    (DW),
    .AW    (RAW),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_q)
  );

  // Read data is forced to zero for addresses beyond the implemented RAM.
  assign w_rd_data = w_ea_oob ? '0 : w_ram_q;

  // Response data: live RAM output during a read RESP, otherwise the held value.
  always_comb begin
    rsp_rdata = r_rdata;
    if ((r_state == ST_RESP) && !r_wr) begin
      rsp_rdata = w_rd_data;
    end
  end

  // Request FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wr        <= 1'b0;
      r_wdata     <= '0;
      r_ea        <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_rsp_ea    <= '0;
`ifdef ROM_PROTECT_EN
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rsp_valid <= 1'b0;
          if (req_valid) begin
            r_wr        <= req_wr;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (req_indirect) begin
              r_state <= ST_PTR;
            end else begin
              r_ea    <= req_addr;
              r_state <= ST_ACCESS;
            end
          end
        end
        ST_PTR: begin
          // Pointer word bits above the address width are ignored.
          r_ea    <= w_ram_q[AW-1:0];
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          r_rsp_valid <= 1'b1;
          r_rsp_ea    <= r_ea;
          if (r_wr) begin
            r_rdata <= r_wdata;
          end
`ifdef ROM_PROTECT_EN
          r_err <= w_ea_oob | (r_wr & w_rom_hit);
`endif
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_rsp_valid <= 1'b0;
          if (!r_wr) begin
            r_rdata <= w_rd_data;
          end
`ifdef ROM_PROTECT_EN
          r_err <= 1'b0;
`endif
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_ea    = r_rsp_ea;
`ifdef ROM_PROTECT_EN
  assign rsp_err   = r_err;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Testbench for mem_bus_ctrl (DEPTH=512 so the upper half of the address space is out of range).
// Directed steps followed by randomized requests checked against an associative-array memory model.
// Honors ROM_PROTECT_EN when defined.
module tb_mem_bus_ctrl;

  localparam int AW      = 10;
  localparam int DW      = 16;
  localparam int DEPTH   = 512;
  localparam int ROM_TOP = 64;
`ifdef ROM_PROTECT_EN
  localparam logic [AW-1:0] PTR_A   = 10'h0A0;
  localparam logic [AW-1:0] ABORT_A = 10'h050;
`else
  localparam logic [AW-1:0] PTR_A   = 10'h020;
  localparam logic [AW-1:0] ABORT_A = 10'h010;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wr = 1'b0;
  logic          req_indirect = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] rsp_ea;
  logic          busy;
`ifdef ROM_PROTECT_EN
  logic          rsp_err;
`endif

  always #5 clk = ~clk;

  mem_bus_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .ROM_TOP(ROM_TOP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_indirect (req_indirect),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_ea       (rsp_ea),
    .busy         (busy)
`ifdef ROM_PROTECT_EN
    ,
    .rsp_err      (rsp_err)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference memory: only addresses written through the bus are known.
  logic [DW-1:0] m_mem [int];
  int            known_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit writable(input int ea);
`ifdef ROM_PROTECT_EN
    return (ea < DEPTH) && (ea >= ROM_TOP);
`else
    return ea < DEPTH;
`endif
  endfunction

  // Issue one request and wait (bounded) for its response strobe.
  task automatic do_req(input bit wr, input bit ind, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                        output logic [AW-1:0] ea, output logic err, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wr = wr; req_indirect = ind; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_wdata = DW'($urandom);
    lat = 0; rd = '0; ea = '0; err = 1'b0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    rd = rsp_rdata;
    ea = rsp_ea;
`ifdef ROM_PROTECT_EN
    err = rsp_err;
`endif
  endtask

  // One request checked against the model's view of the memory.
  task automatic model_op(input bit wr, input bit ind, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input string tag);
    logic [DW-1:0] rd, exp_d, ptr;
    logic [AW-1:0] ea;
    logic          err;
    int            lat, ea_exp;
    if (ind) begin
      ptr = m_mem[int'(addr)];
      ea_exp = int'(ptr[AW-1:0]);
    end else begin
      ea_exp = int'(addr);
    end
    if (wr) exp_d = wd;
    else if (ea_exp < DEPTH && m_mem.exists(ea_exp)) exp_d = m_mem[ea_exp];
    else exp_d = '0;
    do_req(wr, ind, addr, wd, rd, ea, err, lat);
    check({tag, "_lat"}, lat, ind ? 3 : 2);
    check({tag, "_ea"}, 32'(ea), ea_exp);
    check({tag, "_data"}, 32'(rd), 32'(exp_d));
`ifdef ROM_PROTECT_EN
    check({tag, "_err"}, 32'(err), ((ea_exp >= DEPTH) || (wr && ea_exp < ROM_TOP)) ? 1 : 0);
`endif
    @(negedge clk);
    check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    if (wr && writable(ea_exp)) begin
      if (!m_mem.exists(ea_exp)) known_q.push_back(ea_exp);
      m_mem[ea_exp] = wd;
    end
  endtask

  task automatic pick_read_target(output logic [AW-1:0] a);
    if (known_q.size() == 0 || $urandom_range(0, 3) == 0) a = AW'($urandom_range(DEPTH, 1023));
    else a = AW'(known_q[$urandom_range(0, known_q.size() - 1)]);
  endtask

  logic [AW-1:0] cont_a [3];
  int            rsp_cyc [3];
  logic [DW-1:0] rsp_d [3];
  logic [AW-1:0] rsp_a [3];
  int            acc, nrsp, kind;
  logic [AW-1:0] ra, tgt;
  logic [DW-1:0] rdv;

  initial begin
    // Reset state
    #12;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_ea", 32'(rsp_ea), 32'd0);
`ifdef ROM_PROTECT_EN
    check("rst_err", 32'(rsp_err), 32'd0);
`endif
    @(negedge clk) rst_n = 1'b1;

    // Direct write then read back
    model_op(1, 0, 10'h100, 16'hBEEF, "dir_wr");
    model_op(0, 0, 10'h100, 16'h0000, "dir_rd");

    // Indirect read; pointer upper bits ignored
    model_op(1, 0, PTR_A, 16'hFC55, "pre_ptr");
    model_op(1, 0, 10'h055, 16'h1234, "pre_tgt");
    model_op(0, 1, PTR_A, 16'h0000, "ind_rd");

    // Self-pointing indirect
    model_op(1, 0, 10'h0C0, 16'h08C0, "self_pre");
    model_op(0, 1, 10'h0C0, 16'h0000, "self_rd");

    // req_valid held high across three direct reads
    cont_a[0] = 10'h100; cont_a[1] = 10'h055; cont_a[2] = PTR_A;
    acc = 0; nrsp = 0;
    for (int c = 0; c < 16; c++) begin
      if (rsp_valid) begin
        if (nrsp < 3) begin
          rsp_cyc[nrsp] = c; rsp_d[nrsp] = rsp_rdata; rsp_a[nrsp] = rsp_ea;
        end
        nrsp++;
      end
      if (busy) check("cont_ready_low", 32'(req_ready), 32'd0);
      if (acc < 3) begin
        req_valid = 1'b1; req_wr = 1'b0; req_indirect = 1'b0; req_addr = cont_a[acc];
        if (req_ready) acc++;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("cont_nrsp", nrsp, 3);
    if (nrsp >= 3) begin
      for (int i = 0; i < 3; i++) begin
        check("cont_data", 32'(rsp_d[i]), 32'(m_mem[int'(cont_a[i])]));
        check("cont_ea", 32'(rsp_a[i]), 32'(cont_a[i]));
      end
      check("cont_gap1", rsp_cyc[1] - rsp_cyc[0], 3);
      check("cont_gap2", rsp_cyc[2] - rsp_cyc[1], 3);
    end

    // Reset during pointer fetch of an indirect write: write is lost
    model_op(1, 0, ABORT_A, 16'h1357, "abort_pre");
    model_op(1, 0, 10'h0B0, 16'(ABORT_A), "abort_ptr");
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_indirect = 1'b1; req_addr = 10'h0B0; req_wdata = 16'hAAAA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_rdata", 32'(rsp_rdata), 32'd0);
    check("abort_ea", 32'(rsp_ea), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    model_op(0, 0, ABORT_A, 16'h0000, "abort_rd");

    // Out-of-range: write dropped, read returns zero
    model_op(1, 0, 10'h300, 16'h5555, "oob_wr");
    model_op(0, 0, 10'h300, 16'h0000, "oob_rd");

`ifdef ROM_PROTECT_EN
    // Protected region rejects writes; first writable word accepts
    model_op(1, 0, 10'h010, 16'h7777, "rom_wr");
    model_op(1, 0, 10'h040, 16'h4444, "rom_edge_wr");
    model_op(0, 0, 10'h040, 16'h0000, "rom_edge_rd");
`endif

    // Read-after-write in consecutive requests
    model_op(1, 0, 10'h1F0, 16'hC0DE, "raw_wr");
    model_op(0, 0, 10'h1F0, 16'h0000, "raw_rd");

    // Randomized mix of direct and indirect reads and writes
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      rdv = DW'($urandom);
      case (kind)
        0: model_op(1, 0, AW'($urandom_range(0, 1023)), rdv, "rnd_wr");
        1: begin
          pick_read_target(ra);
          model_op(0, 0, ra, rdv, "rnd_rd");
        end
        default: begin
          if (kind == 3) pick_read_target(tgt);
          else tgt = AW'($urandom_range(0, 1023));
          ra = AW'($urandom_range(ROM_TOP, DEPTH - 1));
          model_op(1, 0, ra, {6'($urandom), tgt}, "rnd_ptr");
          model_op(kind == 2, 1, ra, rdv, (kind == 2) ? "rnd_iwr" : "rnd_ird");
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
